// File: rtl/axi_multi_bridge.sv
// rtl/axi_multi_bridge.sv - N-port cache read arbiter plus single-entry write buffer onto one AXI3 master.
// Optional AXI_RR_ARB_EN selects round-robin read arbitration instead of fixed priority.
module axi_multi_bridge #(
  parameter int NUM_RD     = 2,
  parameter int LINE_WORDS = 4,
  parameter int ID_W       = 4
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [NUM_RD-1:0]       rd_req,
  input  logic [3*NUM_RD-1:0]     rd_type,
  input  logic [32*NUM_RD-1:0]    rd_addr,
  output logic [NUM_RD-1:0]       rd_rdy,
  output logic [NUM_RD-1:0]       ret_valid,
  output logic                    ret_last,
  output logic [31:0]             ret_data,
  input  logic                    wr_req,
  input  logic [2:0]              wr_type,
  input  logic [31:0]             wr_addr,
  input  logic [3:0]              wr_wstrb,
  input  logic [32*LINE_WORDS-1:0] wr_data,
  output logic                    wr_rdy,
  output logic                    write_buffer_empty,
  output logic [ID_W-1:0]         arid,
  output logic [31:0]             araddr,
  output logic [7:0]              arlen,
  output logic [2:0]              arsize,
  output logic [1:0]              arburst,
  output logic [1:0]              arlock,
  output logic [3:0]              arcache,
  output logic [2:0]              arprot,
  output logic                    arvalid,
  input  logic                    arready,
  input  logic [ID_W-1:0]         rid,
  input  logic [31:0]             rdata,
  input  logic [1:0]              rresp,
  input  logic                    rlast,
  input  logic                    rvalid,
  output logic                    rready,
  output logic [ID_W-1:0]         awid,
  output logic [31:0]             awaddr,
  output logic [7:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic [1:0]              awlock,
  output logic [3:0]              awcache,
  output logic [2:0]              awprot,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [ID_W-1:0]         wid,
  output logic [31:0]             wdata,
  output logic [3:0]              wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [ID_W-1:0]         bid,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready
);

  localparam int OFF   = $clog2(4 * LINE_WORDS);
  localparam int IDX_W = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
  localparam int CNT_W = $clog2(LINE_WORDS);
  localparam logic [7:0] LINE_LEN = 8'(LINE_WORDS - 1);

  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_t;

  r_state_t r_state, r_next;
  w_state_t w_state, w_next;

  logic [31:0]      r_addr;
  logic [2:0]       r_type;
  logic [IDX_W-1:0] r_id;

  logic [31:0]      w_addr;
  logic [2:0]       w_type;
  logic [3:0]       w_strb;
  logic [31:0]      w_buf [LINE_WORDS];
  logic [CNT_W-1:0] w_cnt;
  logic             w_done;
  logic             last_beat;

  logic [NUM_RD-1:0] cand;
  logic              found;
  logic [IDX_W-1:0]  win;

  logic unused_inputs;
  assign unused_inputs = ^{rid, rresp, bid, bresp};

  // A read is held off only while its line sits in the write buffer.
  always_comb begin
    for (int i = 0; i < NUM_RD; i++)
      cand[i] = rd_req[i] && !((w_state != W_IDLE) &&
                (rd_addr[32*i+OFF +: 32-OFF] == w_addr[31:OFF]));
  end

`ifdef AXI_RR_ARB_EN
  logic [IDX_W-1:0] rr_ptr;

  always_comb begin
    int idx;
    found = 1'b0;
    win   = '0;
    for (int k = NUM_RD - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NUM_RD;
      if (cand[idx]) begin
        found = 1'b1;
        win   = IDX_W'(idx);
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)
      rr_ptr <= '0;
    else if (r_state == R_IDLE && found)
      rr_ptr <= (int'(win) == NUM_RD - 1) ? '0 : win + 1'b1;
  end
`else
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = NUM_RD - 1; i >= 0; i--) begin
      if (cand[i]) begin
        found = 1'b1;
        win   = IDX_W'(i);
      end
    end
  end
`endif

  always_comb begin
    r_next    = r_state;
    rd_rdy    = '0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    ret_valid = '0;
    ret_last  = 1'b0;
    ret_data  = '0;
    case (r_state)
      R_IDLE: if (found) begin
        rd_rdy[win] = 1'b1;
        r_next      = R_AR;
      end
      R_AR: begin
        arvalid = 1'b1;
        if (arready) r_next = R_DATA;
      end
      R_DATA: begin
        rready = 1'b1;
        if (rvalid) begin
          ret_valid[r_id] = 1'b1;
          ret_data        = rdata;
          ret_last        = rlast;
          if (rlast) r_next = R_IDLE;
        end
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= R_IDLE;
      r_addr  <= '0;
      r_type  <= '0;
      r_id    <= '0;
    end else begin
      r_state <= r_next;
      if (r_state == R_IDLE && found) begin
        r_addr <= rd_addr[32*win +: 32];
        r_type <= rd_type[3*win +: 3];
        r_id   <= win;
      end
    end
  end

  assign arid    = ID_W'(r_id);
  assign araddr  = r_addr;
  assign arlen   = r_type[2] ? LINE_LEN : 8'd0;
  assign arsize  = r_type[2] ? 3'd2 : {1'b0, r_type[1:0]};
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;

  assign last_beat = w_type[2] ? (w_cnt == CNT_W'(LINE_WORDS - 1)) : 1'b1;

  // W beats may run ahead of the AW handshake; w_done remembers a finished burst.
  always_comb begin
    w_next  = w_state;
    wr_rdy  = (w_state == W_IDLE) && wr_req;
    awvalid = (w_state == W_ADDR);
    wvalid  = ((w_state == W_ADDR) || (w_state == W_DATA)) && !w_done;
    bready  = (w_state == W_RESP);
    case (w_state)
      W_IDLE: if (wr_req) w_next = W_ADDR;
      W_ADDR: if (awready)
        w_next = (w_done || (wvalid && wready && last_beat)) ? W_RESP : W_DATA;
      W_DATA: if (wready && last_beat) w_next = W_RESP;
      W_RESP: if (bvalid) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state <= W_IDLE;
      w_addr  <= '0;
      w_type  <= '0;
      w_strb  <= '0;
      w_cnt   <= '0;
      w_done  <= 1'b0;
      for (int i = 0; i < LINE_WORDS; i++) w_buf[i] <= '0;
    end else begin
      w_state <= w_next;
      if (wr_rdy) begin
        w_addr <= wr_addr;
        w_type <= wr_type;
        w_strb <= wr_wstrb;
        w_cnt  <= '0;
        w_done <= 1'b0;
        for (int i = 0; i < LINE_WORDS; i++) w_buf[i] <= wr_data[32*i +: 32];
      end else if (wvalid && wready) begin
        if (last_beat) w_done <= 1'b1;
        else           w_cnt  <= w_cnt + 1'b1;
      end
    end
  end

  assign write_buffer_empty = (w_state == W_IDLE);
  assign awid    = '0;
  assign wid     = '0;
  assign awaddr  = w_addr;
  assign awlen   = w_type[2] ? LINE_LEN : 8'd0;
  assign awsize  = w_type[2] ? 3'd2 : {1'b0, w_type[1:0]};
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'b0000;
  assign awprot  = 3'b000;
  assign wdata   = w_buf[w_cnt];
  assign wstrb   = w_type[2] ? 4'hf : w_strb;
  assign wlast   = wvalid && last_beat;

endmodule

// File: tb/tb_axi_multi_bridge.sv
// tb/tb_axi_multi_bridge.sv - scoreboard bench for axi_multi_bridge with a simple AXI slave.
module tb_axi_multi_bridge;
  localparam int NUM_RD = 2, LINE_WORDS = 4, ID_W = 4;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;
  logic aresetn;

  logic [NUM_RD-1:0] rd_req, rd_rdy, ret_valid;
  logic [3*NUM_RD-1:0] rd_type;
  logic [32*NUM_RD-1:0] rd_addr;
  logic ret_last, wr_req, wr_rdy, write_buffer_empty;
  logic [31:0] ret_data, wr_addr;
  logic [2:0] wr_type;
  logic [3:0] wr_wstrb;
  logic [32*LINE_WORDS-1:0] wr_data;
  logic [ID_W-1:0] arid, rid, awid, wid, bid;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [7:0] arlen, awlen;
  logic [2:0] arsize, arprot, awsize, awprot;
  logic [1:0] arburst, arlock, rresp, awburst, awlock, bresp;
  logic [3:0] arcache, awcache, wstrb;
  logic arvalid, arready, rlast, rvalid, rready;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  axi_multi_bridge #(.NUM_RD(NUM_RD), .LINE_WORDS(LINE_WORDS), .ID_W(ID_W)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
    .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
    .wr_data(wr_data), .wr_rdy(wr_rdy), .write_buffer_empty(write_buffer_empty),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  typedef struct packed {logic [ID_W-1:0] id; logic [31:0] addr; logic [7:0] len; logic [2:0] size;} ar_t;
  typedef struct packed {logic [NUM_RD-1:0] valid; logic [31:0] data; logic last;} ret_t;
  typedef struct packed {logic [31:0] addr; logic [7:0] len; logic [2:0] size;} aw_t;
  typedef struct packed {logic [31:0] data; logic [3:0] strb; logic last;} w_t;

  ar_t ar_q[$];
  ret_t ret_q[$];
  aw_t aw_q[$];
  w_t w_q[$];

  int n_checks = 0, n_fail = 0;
  logic [31:0] r_seed = 32'h0;
  int b_delay = 0;

  logic [43:0] outs;
  assign outs = {rd_rdy, ret_valid, ret_last, ret_data, wr_rdy, write_buffer_empty,
                 arvalid, rready, awvalid, wvalid, bready};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitors
  always @(negedge aclk) if (aresetn === 1'b1) begin
    if (arvalid && arready) begin
      if (ar_q.size() == 0) chk("ar_unexpected", 64'd1, 64'd0);
      else begin
        ar_t e;
        e = ar_q.pop_front();
        chk("ar", 64'({arid, araddr, arlen, arsize}), 64'(e));
      end
    end
    if (|ret_valid) begin
      if (ret_q.size() == 0) chk("ret_unexpected", 64'd1, 64'd0);
      else begin
        ret_t e;
        e = ret_q.pop_front();
        chk("ret", 64'({ret_valid, ret_data, ret_last}), 64'(e));
      end
    end
    if (awvalid && awready) begin
      if (aw_q.size() == 0) chk("aw_unexpected", 64'd1, 64'd0);
      else begin
        aw_t e;
        e = aw_q.pop_front();
        chk("aw", 64'({awaddr, awlen, awsize}), 64'(e));
      end
    end
    if (wvalid && wready) begin
      if (w_q.size() == 0) chk("w_unexpected", 64'd1, 64'd0);
      else begin
        w_t e;
        e = w_q.pop_front();
        chk("w", 64'({wdata, wstrb, wlast}), 64'(e));
      end
    end
  end

  // Read slave: beat b of a burst carries r_seed + b
  initial begin
    arready = 1'b1; rvalid = 1'b0; rlast = 1'b0; rdata = '0; rid = '0; rresp = 2'b00;
    forever begin
      @(negedge aclk);
      if (aresetn && arvalid && arready) begin
        int len;
        logic [ID_W-1:0] id;
        len = int'(arlen);
        id = arid;
        for (int b = 0; b <= len; b++) begin
          @(posedge aclk); #1;
          if (!aresetn) break;
          rvalid = 1'b1; rdata = r_seed + 32'(b); rlast = (b == len); rid = id;
        end
        if (aresetn) begin
          @(posedge aclk); #1;
        end
        rvalid = 1'b0; rlast = 1'b0;
      end
    end
  end

  // Write slave: response delayed by b_delay cycles after the last W beat
  initial begin
    awready = 1'b1; wready = 1'b1; bvalid = 1'b0; bid = '0; bresp = 2'b00;
    forever begin
      @(negedge aclk);
      if (aresetn && wvalid && wready && wlast) begin
        @(posedge aclk);
        repeat (b_delay) @(posedge aclk);
        #1 bvalid = 1'b1;
        @(posedge aclk); #1 bvalid = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic issue_read(input int port, input logic [2:0] typ, input logic [31:0] addr);
    ar_t a;
    ret_t r;
    int beats;
    bit got;
    @(posedge aclk); #1;
    rd_req[port] = 1'b1;
    rd_type[3*port +: 3] = typ;
    rd_addr[32*port +: 32] = addr;
    got = 1'b0;
    for (int c = 0; c < 30 && !got; c++) begin
      @(negedge aclk);
      if (rd_rdy[port]) got = 1'b1;
    end
    chk($sformatf("grant_p%0d", port), 64'(got), 64'd1);
    beats = typ[2] ? LINE_WORDS : 1;
    a.id = ID_W'(port); a.addr = addr; a.len = 8'(beats - 1);
    a.size = typ[2] ? 3'd2 : {1'b0, typ[1:0]};
    ar_q.push_back(a);
    for (int b = 0; b < beats; b++) begin
      r.valid = NUM_RD'(1 << port); r.data = r_seed + 32'(b); r.last = (b == beats - 1);
      ret_q.push_back(r);
    end
    @(posedge aclk); #1;
    rd_req[port] = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge aclk);
      if (ar_q.size() == 0 && ret_q.size() == 0 && aw_q.size() == 0 && w_q.size() == 0 &&
          write_buffer_empty && !rvalid && !bvalid) ok = 1'b1;
    end
    chk(name, 64'(ok), 64'd1);
  endtask

`ifdef AXI_RR_ARB_EN
  int exp_g[4] = '{0, 1, 0, 1};
`else
  int exp_g[4] = '{0, 0, 0, 0};
`endif

  initial begin
    bit got, held_bad;
    int nb;
    aresetn = 1'b0;
    rd_req = '0; rd_type = '0; rd_addr = '0;
    wr_req = 1'b0; wr_type = '0; wr_addr = '0; wr_wstrb = '0; wr_data = '0;
    repeat (2) @(negedge aclk);
    chk("reset_outputs", 64'(outs), 64'h20);
    @(posedge aclk); #1 aresetn = 1'b1;

    // T1: port0 line read
    r_seed = 32'h0;
    issue_read(0, 3'b100, 32'h1c000000);
    @(negedge aclk);
    chk("t1_ar_latency", 64'(arvalid), 64'd1);
    wait_idle("t1_idle");

    // T2: port1 word read
    r_seed = 32'h55;
    issue_read(1, 3'b010, 32'h1faf0000);
    wait_idle("t2_idle");

    // T3: both ports requesting continuously
    r_seed = 32'h300;
    @(posedge aclk); #1;
    rd_req = 2'b11; rd_type = {3'b010, 3'b010}; rd_addr = {32'h1c000200, 32'h1c000100};
    for (int k = 0; k < 4; k++) begin
      ar_t a;
      ret_t r;
      got = 1'b0;
      for (int c = 0; c < 30 && !got; c++) begin
        @(negedge aclk);
        if (|rd_rdy) got = 1'b1;
      end
      chk($sformatf("t3_grant%0d", k), 64'(rd_rdy), 64'(1 << exp_g[k]));
      a.id = ID_W'(exp_g[k]); a.addr = exp_g[k] ? 32'h1c000200 : 32'h1c000100;
      a.len = 8'd0; a.size = 3'd2;
      ar_q.push_back(a);
      r.valid = NUM_RD'(1 << exp_g[k]); r.data = 32'h300; r.last = 1'b1;
      ret_q.push_back(r);
    end
    @(posedge aclk); #1 rd_req = '0;
    wait_idle("t3_idle");

    // T4: line write with delayed response; T5: RAW-blocked read of the same line
    b_delay = 5;
    @(posedge aclk); #1;
    wr_req = 1'b1; wr_type = 3'b100; wr_addr = 32'h1c000040; wr_wstrb = 4'h0;
    wr_data = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
    aw_q.push_back('{addr: 32'h1c000040, len: 8'd3, size: 3'd2});
    w_q.push_back('{data: 32'hAAAA0000, strb: 4'hf, last: 1'b0});
    w_q.push_back('{data: 32'hBBBB0001, strb: 4'hf, last: 1'b0});
    w_q.push_back('{data: 32'hCCCC0002, strb: 4'hf, last: 1'b0});
    w_q.push_back('{data: 32'hDDDD0003, strb: 4'hf, last: 1'b1});
    @(negedge aclk);
    chk("t4_wr_rdy", 64'(wr_rdy), 64'd1);
    @(posedge aclk); #1;
    wr_req = 1'b0;
    r_seed = 32'h500;
    rd_req[0] = 1'b1; rd_type[2:0] = 3'b010; rd_addr[31:0] = 32'h1c000048;
    @(negedge aclk);
    chk("t4_wbe_pending", 64'(write_buffer_empty), 64'd0);
    got = 1'b0; held_bad = 1'b0;
    if (bvalid) got = 1'b1;
    else if (rd_rdy != 0) held_bad = 1'b1;
    for (int c = 0; c < 60 && !got; c++) begin
      @(negedge aclk);
      if (bvalid) got = 1'b1;
      else if (rd_rdy != 0 || write_buffer_empty) held_bad = 1'b1;
    end
    chk("t5_bvalid_seen", 64'(got), 64'd1);
    chk("t5_rd_blocked", 64'(held_bad), 64'd0);
    chk("t5_at_bvalid", 64'({rd_rdy, write_buffer_empty}), 64'b000);
    ar_q.push_back('{id: ID_W'(0), addr: 32'h1c000048, len: 8'd0, size: 3'd2});
    ret_q.push_back('{valid: 2'b01, data: 32'h500, last: 1'b1});
    @(negedge aclk);
    chk("t5_after_bvalid", 64'({rd_rdy, write_buffer_empty}), 64'b011);
    @(posedge aclk); #1 rd_req = '0;
    @(negedge aclk);
    chk("t5_arvalid", 64'(arvalid), 64'd1);
    wait_idle("t5_idle");

    // Read of the line being accepted in the same cycle is not blocked
    b_delay = 0;
    r_seed = 32'h800;
    @(posedge aclk); #1;
    wr_req = 1'b1; wr_type = 3'b010; wr_addr = 32'h1c000300; wr_wstrb = 4'h3;
    wr_data = {96'h0, 32'h12345678};
    rd_req[1] = 1'b1; rd_type[5:3] = 3'b010; rd_addr[63:32] = 32'h1c000304;
    aw_q.push_back('{addr: 32'h1c000300, len: 8'd0, size: 3'd2});
    w_q.push_back('{data: 32'h12345678, strb: 4'h3, last: 1'b1});
    ar_q.push_back('{id: ID_W'(1), addr: 32'h1c000304, len: 8'd0, size: 3'd2});
    ret_q.push_back('{valid: 2'b10, data: 32'h800, last: 1'b1});
    @(negedge aclk);
    chk("t7_both_rdy", 64'({rd_rdy, wr_rdy}), 64'b101);
    @(posedge aclk); #1 wr_req = 1'b0; rd_req = '0;
    wait_idle("t7_idle");

    // T6: reset during the third return beat
    r_seed = 32'h600;
    issue_read(0, 3'b100, 32'h1c000500);
    nb = 0;
    for (int c = 0; c < 30 && nb < 3; c++) begin
      @(negedge aclk);
      if (ret_valid[0]) nb++;
    end
    chk("t6_reached_beat2", 64'(nb), 64'd3);
    #1 aresetn = 1'b0;
    ar_q.delete();
    ret_q.delete();
    @(negedge aclk);
    chk("t6_reset_outputs", 64'(outs), 64'h20);
    @(posedge aclk); #1;
    @(posedge aclk); #1 aresetn = 1'b1;
    r_seed = 32'h700;
    issue_read(1, 3'b010, 32'h1c000600);
    wait_idle("t6_fresh_read");

    chk("queues_empty", 64'(ar_q.size() + ret_q.size() + aw_q.size() + w_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
